me_result_collector: RTL and testbench

- Downstream stage of the full-search motion estimator core.
- Sequences the core across every macroblock of a frame in raster order, driving its start input and waiting for each completed pulse.
- Captures each result {BestDist, motionX, motionY} and tags it with the macroblock coordinate.
- Buffers results in a FIFO with a valid/ready output and keeps a saturating frame-level SAD total.

---
 rtl/me_result_collector.sv | 182 ++++++++++++++++++
 tb/tb_me_result_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_result_collector.sv
// Sequences the full-search motion estimator over every macroblock of a frame,
// tags each result with its block coordinate and queues it in a FWFT FIFO.
module me_result_collector #(
    parameter int BLOCKS_X   = 4,
    parameter int BLOCKS_Y   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIST_W     = 8,
    parameter int MV_W       = 4,
    parameter int ACC_W      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        frame_go,
    output logic                        me_start,
    input  logic                        me_completed,
    input  logic [DIST_W-1:0]           me_best_dist,
    input  logic [MV_W-1:0]             me_motion_x,
    input  logic [MV_W-1:0]             me_motion_y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(BLOCKS_X)-1:0] out_blk_x,
    output logic [$clog2(BLOCKS_Y)-1:0] out_blk_y,
    output logic [MV_W-1:0]             out_mv_x,
    output logic [MV_W-1:0]             out_mv_y,
    output logic [DIST_W-1:0]           out_dist,
    output logic [ACC_W-1:0]            frame_sad,
    output logic                        frame_done
);

    localparam int XW    = $clog2(BLOCKS_X);
    localparam int YW    = $clog2(BLOCKS_Y);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int EW    = XW + YW + 2 * MV_W + DIST_W;
    localparam int SUM_W = ((ACC_W > DIST_W) ? ACC_W : DIST_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [XW-1:0]    X_LAST  = XW'(BLOCKS_X - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(BLOCKS_Y - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        PUSH      = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]  acc,
                                                 input logic [DIST_W-1:0] d);
        logic [SUM_W-1:0] s;
        s = SUM_W'(acc) + SUM_W'(d);
        if (s > SUM_W'(ACC_MAX))
            return ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    state_t             state, state_nxt;
    logic               comp_q;
    logic               comp_rise;
    logic [XW-1:0]      blk_x;
    logic [YW-1:0]      blk_y;
    logic [ACC_W-1:0]   sad_acc;
    logic               last_blk;
    logic               start_frame;
    logic               cap_en;

    logic [XW-1:0]      cap_x;
    logic [YW-1:0]      cap_y;
    logic [MV_W-1:0]    cap_mv_x;
    logic [MV_W-1:0]    cap_mv_y;
    logic [DIST_W-1:0]  cap_dist;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               pop, push, fifo_ok;
    logic [EW-1:0]      head;

    assign comp_rise = me_completed & ~comp_q;
    assign last_blk  = (blk_x == X_LAST) && (blk_y == Y_LAST);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_ok   = (count != FULL_CNT) | pop;
    assign push      = (state == PUSH) & fifo_ok;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (frame_go) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (comp_rise) state_nxt = PUSH;
            PUSH:      if (push) state_nxt = last_blk ? DONE : LAUNCH;
            DONE:      if (frame_go) state_nxt = LAUNCH;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        me_start    = (state == LAUNCH) || (state == WAIT_DONE);
        frame_done  = (state == DONE);
        start_frame = ((state == IDLE) || (state == DONE)) && frame_go;
        cap_en      = (state == WAIT_DONE) && comp_rise;
    end

    // Control: completed edge, raster counters, frame total
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            comp_q  <= 1'b0;
            blk_x   <= '0;
            blk_y   <= '0;
            sad_acc <= '0;
        end else begin
            comp_q <= me_completed;
            if (start_frame) begin
                blk_x   <= '0;
                blk_y   <= '0;
                sad_acc <= '0;
            end else if (push) begin
                sad_acc <= sat_add(sad_acc, cap_dist);
                if (!last_blk) begin
                    if (blk_x == X_LAST) begin
                        blk_x <= '0;
                        blk_y <= blk_y + 1'b1;
                    end else begin
                        blk_x <= blk_x + 1'b1;
                    end
                end
            end
        end
    end

    assign frame_sad = sad_acc;

    // Capture register holds the result while a full FIFO stalls the push
    always_ff @(posedge clock) begin
        if (cap_en) begin
            cap_x    <= blk_x;
            cap_y    <= blk_y;
            cap_mv_x <= me_motion_x;
            cap_mv_y <= me_motion_y;
            cap_dist <= me_best_dist;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {cap_x, cap_y, cap_mv_x, cap_mv_y, cap_dist};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is masked when empty so stale memory never shows on the outputs
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_blk_x, out_blk_y, out_mv_x, out_mv_y, out_dist} = head;

endmodule

// File: tb/tb_me_result_collector.sv
// Randomised scoreboard bench for me_result_collector: a behavioural estimator
// core feeds results, a monitor pops and compares every delivered entry.
module tb_me_result_collector;

    localparam int BX = 4, BY = 4, DEPTH = 8, DW = 8, MW = 4, AW = 16;

    typedef struct packed {
        logic [1:0]    x;
        logic [1:0]    y;
        logic [MW-1:0] mx;
        logic [MW-1:0] my;
        logic [DW-1:0] d;
    } ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n = 1'b0;
    logic          frame_go;
    logic          me_start, me_completed;
    logic [DW-1:0] me_best_dist;
    logic [MW-1:0] me_motion_x, me_motion_y;
    logic          out_valid, out_ready;
    logic [1:0]    out_blk_x, out_blk_y;
    logic [MW-1:0] out_mv_x, out_mv_y;
    logic [DW-1:0] out_dist;
    logic [AW-1:0] frame_sad;
    logic          frame_done;

    logic          go_s, start_s, comp_s, valid_s, ready_s;
    logic [DW-1:0] dist_in_s, dist_s;
    logic [MW-1:0] mvx_in_s, mvy_in_s, mvx_s, mvy_s;
    logic [1:0]    bx_s, by_s;
    logic [7:0]    sad_s;
    logic          done_s;

    me_result_collector #(.BLOCKS_X(BX), .BLOCKS_Y(BY), .FIFO_DEPTH(DEPTH),
                          .DIST_W(DW), .MV_W(MW), .ACC_W(AW)) dut (
        .clock(clock), .reset_n(reset_n), .frame_go(frame_go), .me_start(me_start),
        .me_completed(me_completed), .me_best_dist(me_best_dist),
        .me_motion_x(me_motion_x), .me_motion_y(me_motion_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_blk_x(out_blk_x),
        .out_blk_y(out_blk_y), .out_mv_x(out_mv_x), .out_mv_y(out_mv_y),
        .out_dist(out_dist), .frame_sad(frame_sad), .frame_done(frame_done));

    me_result_collector #(.BLOCKS_X(BX), .BLOCKS_Y(BY), .FIFO_DEPTH(DEPTH),
                          .DIST_W(DW), .MV_W(MW), .ACC_W(8)) dut_sat (
        .clock(clock), .reset_n(reset_n), .frame_go(go_s), .me_start(start_s),
        .me_completed(comp_s), .me_best_dist(dist_in_s),
        .me_motion_x(mvx_in_s), .me_motion_y(mvy_in_s),
        .out_valid(valid_s), .out_ready(ready_s), .out_blk_x(bx_s),
        .out_blk_y(by_s), .out_mv_x(mvx_s), .out_mv_y(mvy_s),
        .out_dist(dist_s), .frame_sad(sad_s), .frame_done(done_s));

    int     checks = 0, errors = 0;
    ent_t   sb[$];
    int     blk_k = 0;
    longint sad_model = 0;
    int     n_pop = 0;
    int     rdy_mode = 1;
    int     core_delay = 20;
    bit     core_fixed = 1, core_rand = 0, core_hold = 0;
    bit     sat_done = 0;
    int     pops_s = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural estimator core: completes a fixed or random number of cycles after start
    initial begin
        bit start_seen;
        int wait_cnt;
        ent_t e;
        start_seen = 0; wait_cnt = 0;
        me_completed = 0; me_best_dist = '0; me_motion_x = '0; me_motion_y = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                start_seen = 0;
                me_completed = 0;
            end else if (!me_start) begin
                start_seen = 0;
                if (!core_hold) me_completed = 0;
            end else if (!start_seen) begin
                start_seen = 1;
                wait_cnt = core_rand ? int'($urandom_range(1, 6)) : core_delay;
            end else if (wait_cnt > 1) begin
                wait_cnt--;
            end else if (wait_cnt == 1) begin
                if (me_completed) begin
                    me_completed = 0;
                end else begin
                    wait_cnt = 0;
                    if (core_fixed) begin
                        me_best_dist = 8'h10; me_motion_x = 4'h3; me_motion_y = 4'hE;
                    end else begin
                        me_best_dist = DW'($urandom);
                        me_motion_x  = MW'($urandom);
                        me_motion_y  = MW'($urandom);
                    end
                    me_completed = 1;
                    e.x  = 2'(blk_k % BX);
                    e.y  = 2'(blk_k / BX);
                    e.mx = me_motion_x;
                    e.my = me_motion_y;
                    e.d  = me_best_dist;
                    sb.push_back(e);
                    sad_model = sad_model + me_best_dist;
                    if (sad_model > 65535) sad_model = 65535;
                    blk_k++;
                end
            end
        end
    end

    // Monitor: drives out_ready and checks each popped entry against the queue
    initial begin
        ent_t got, exp;
        out_ready = 0;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       out_ready = 0;
                1:       out_ready = 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                got = {out_blk_x, out_blk_y, out_mv_x, out_mv_y, out_dist};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL entry: got 0x%0h with nothing expected", got);
                end else begin
                    exp = sb.pop_front();
                    chk("entry", 64'(got), 64'(exp));
                end
                n_pop++;
            end
        end
    end

    // Saturation instance: every block reports 0xFF
    initial begin
        int cnt_s;
        cnt_s = 0; comp_s = 0; ready_s = 1;
        dist_in_s = 8'hFF; mvx_in_s = 4'h1; mvy_in_s = 4'hF;
        forever begin
            @(negedge clock);
            if (!start_s) begin
                cnt_s = 0;
                comp_s = 0;
            end else begin
                cnt_s++;
                if (cnt_s == 3) comp_s = 1;
            end
            if (valid_s) begin
                chk("sat_dist", 64'(dist_s), 64'h0FF);
                chk("sat_sad_run", 64'(sad_s), 64'h0FF);
                pops_s++;
            end
        end
    end

    initial begin
        go_s = 0;
        @(posedge reset_n);
        @(negedge clock); go_s = 1;
        @(negedge clock); go_s = 0;
        for (int i = 0; i < 600 && !done_s; i++) @(negedge clock);
        chk("sat_done", 64'(done_s), 64'h1);
        chk("sat_sad", 64'(sad_s), 64'h0FF);
        repeat (4) @(negedge clock);
        chk("sat_pops", 64'(pops_s), 64'd16);
        sat_done = 1;
    end

    task automatic start_frame();
        @(negedge clock);
        frame_go = 1;
        blk_k = 0;
        sad_model = 0;
        n_pop = 0;
        @(negedge clock);
        frame_go = 0;
    endtask

    task automatic finish_frame(input string nm);
        for (int i = 0; i < 3000 && !frame_done; i++) @(negedge clock);
        chk({nm, "_done"}, 64'(frame_done), 64'h1);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clock);
        chk({nm, "_count"}, 64'(n_pop), 64'd16);
        chk({nm, "_sad"}, 64'(frame_sad), 64'(sad_model));
        chk({nm, "_idle_valid"}, 64'(out_valid), 64'h0);
    endtask

    initial begin
        frame_go = 0;
        repeat (3) @(negedge clock);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_start", 64'(me_start), 64'h0);
        chk("rst_done", 64'(frame_done), 64'h0);
        chk("rst_sad", 64'(frame_sad), 64'h0);
        chk("rst_data", 64'({out_blk_x, out_blk_y, out_mv_x, out_mv_y, out_dist}), 64'h0);
        reset_n = 1;

        // Fixed results, consumer always ready
        rdy_mode = 1; core_fixed = 1; core_rand = 0; core_delay = 20;
        start_frame();
        finish_frame("fixed");
        chk("fixed_sad_abs", 64'(frame_sad), 64'h0100);

        // Consumer stalled for the whole frame, then released
        rdy_mode = 0; core_fixed = 0; core_delay = 3;
        start_frame();
        chk("restart_done_drop", 64'(frame_done), 64'h0);
        chk("restart_sad_clr", 64'(frame_sad), 64'h0);
        chk("restart_start", 64'(me_start), 64'h1);
        for (int i = 0; i < 500 && sb.size() < 9; i++) @(negedge clock);
        repeat (10) @(negedge clock);
        chk("stall_captured", 64'(sb.size()), 64'd9);
        chk("stall_start_low", 64'(me_start), 64'h0);
        chk("stall_valid", 64'(out_valid), 64'h1);
        chk("stall_not_done", 64'(frame_done), 64'h0);
        rdy_mode = 1;
        finish_frame("stall");

        // Random readiness and core latency; frame_go mid-frame must be ignored
        rdy_mode = 2; core_rand = 1;
        start_frame();
        for (int i = 0; i < 500 && !(sb.size() + n_pop >= 5 && me_start); i++) @(negedge clock);
        frame_go = 1;
        @(negedge clock);
        frame_go = 0;
        finish_frame("random");

        // Reset mid-frame with three entries queued
        rdy_mode = 0; core_rand = 0; core_delay = 20;
        start_frame();
        for (int i = 0; i < 500 && sb.size() < 3; i++) @(negedge clock);
        repeat (6) @(negedge clock);
        chk("pre_rst_start", 64'(me_start), 64'h1);
        reset_n = 0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_start", 64'(me_start), 64'h0);
        chk("mid_rst_sad", 64'(frame_sad), 64'h0);
        chk("mid_rst_dist", 64'(out_dist), 64'h0);
        sb.delete();
        @(negedge clock);
        reset_n = 1;
        rdy_mode = 1;
        start_frame();
        finish_frame("after_rst");

        // Completed held high across starts: only fresh rising edges capture
        core_hold = 1; core_delay = 4; rdy_mode = 2;
        start_frame();
        finish_frame("hold");
        core_hold = 0;

        for (int i = 0; i < 2000 && !sat_done; i++) @(negedge clock);
        chk("sat_finished", 64'(sat_done), 64'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
